// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and lane constants for the pipelined execute-stage ALU.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD    = 4'h0,
        OP_SUB    = 4'h1,
        OP_XOR    = 4'h2,
        OP_RED    = 4'h3,
        OP_SLL    = 4'h4,
        OP_SRA    = 4'h5,
        OP_ROR    = 4'h6,
        OP_PADDSB = 4'h7,
        OP_LLB    = 4'h8,
        OP_LHB    = 4'h9
    } alu_op_e;

    localparam int FLAG_Z  = 2;
    localparam int FLAG_V  = 1;
    localparam int FLAG_N  = 0;
    localparam int FLAGS_W = 3;

    localparam int LANE_W  = 4;

endpackage

// File: rtl/alu_lanes.sv
// Packed signed saturating adder: WIDTH/LANE_W independent lanes, no carry between lanes.
// Only instantiated by alu_pipe when ALU_PADDSB_EN is defined.
module alu_lanes
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] sum_o
);

    localparam int LANES = WIDTH / LANE_W;

    function automatic logic [LANE_W-1:0] sat_lane(input logic [LANE_W-1:0] x,
                                                   input logic [LANE_W-1:0] y);
        logic signed [LANE_W:0] s;
        s = $signed({x[LANE_W-1], x}) + $signed({y[LANE_W-1], y});
        // Sign bit and guard bit disagree only when the lane overflowed.
        if (s[LANE_W] != s[LANE_W-1]) begin
            return {s[LANE_W], {(LANE_W-1){~s[LANE_W]}}};
        end
        return s[LANE_W-1:0];
    endfunction

    always_comb begin
        sum_o = '0;
        for (int l = 0; l < LANES; l++) begin
            sum_o[l*LANE_W +: LANE_W] = sat_lane(a_i[l*LANE_W +: LANE_W], b_i[l*LANE_W +: LANE_W]);
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage execute ALU with valid/ready handshake and retired {Z,V,N} flags.
// Define ALU_PADDSB_EN to enable opcode 7 (packed 4-bit saturating add); otherwise it is illegal.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         aluop,
    input  logic [WIDTH-1:0]   aluin1,
    input  logic [WIDTH-1:0]   aluin2,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   aluout,
    output logic               err,
    output logic [FLAGS_W-1:0] flags
);

    localparam int SHW = $clog2(WIDTH);

    logic               s1_valid_q, s1_valid_d;
    logic [3:0]         s1_op_q;
    logic [WIDTH-1:0]   s1_a_q;
    logic [WIDTH-1:0]   s1_b_q;

    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   aluout_q, aluout_d;
    logic               err_q, err_d;
    logic               fupd_q, fupd_d;
    logic [FLAGS_W-1:0] flags_q, flags_d;

    logic               accept, s1_adv, retire;
    logic [SHW-1:0]     sh;

    function automatic logic [WIDTH:0] sat_addsub(input logic signed [WIDTH-1:0] a,
                                                  input logic signed [WIDTH-1:0] b,
                                                  input logic                    sub);
        logic signed [WIDTH:0] s;
        if (sub) begin
            s = $signed({a[WIDTH-1], a}) - $signed({b[WIDTH-1], b});
        end else begin
            s = $signed({a[WIDTH-1], a}) + $signed({b[WIDTH-1], b});
        end
        // Result is {err, value}; the guard bit gives the saturation direction.
        if (s[WIDTH] != s[WIDTH-1]) begin
            return {1'b1, s[WIDTH], {(WIDTH-1){~s[WIDTH]}}};
        end
        return {1'b0, s[WIDTH-1:0]};
    endfunction

    function automatic logic [WIDTH-1:0] byte_sum(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] acc;
        acc = '0;
        for (int i = 0; i < WIDTH/8; i++) begin
            acc = acc + WIDTH'(a[i*8 +: 8]) + WIDTH'(b[i*8 +: 8]);
        end
        return acc;
    endfunction

    assign retire   = out_valid_q && out_ready;
    assign s1_adv   = s1_valid_q && (!out_valid_q || out_ready);
    assign in_ready = !s1_valid_q || s1_adv;
    assign accept   = in_valid && in_ready;
    assign sh       = s1_b_q[SHW-1:0];

`ifdef ALU_PADDSB_EN
    logic [WIDTH-1:0] lane_sum;

    alu_lanes #(.WIDTH(WIDTH)) u_lanes (
        .a_i   (s1_a_q),
        .b_i   (s1_b_q),
        .sum_o (lane_sum)
    );
`endif

    // ---- S1 -> S2 boundary: execute ----
    always_comb begin
        aluout_d = '0;
        err_d    = 1'b0;
        fupd_d   = 1'b0;
        case (s1_op_q)
            OP_ADD, OP_SUB: begin
                {err_d, aluout_d} = sat_addsub(s1_a_q, s1_b_q, s1_op_q == OP_SUB);
                fupd_d            = 1'b1;
            end
            OP_XOR: begin
                aluout_d = s1_a_q ^ s1_b_q;
                fupd_d   = 1'b1;
            end
            OP_RED:  aluout_d = byte_sum(s1_a_q, s1_b_q);
            OP_SLL: begin
                aluout_d = s1_a_q << sh;
                fupd_d   = 1'b1;
            end
            OP_SRA: begin
                aluout_d = $unsigned($signed(s1_a_q) >>> sh);
                fupd_d   = 1'b1;
            end
            OP_ROR: begin
                aluout_d = WIDTH'({s1_a_q, s1_a_q} >> sh);
                fupd_d   = 1'b1;
            end
`ifdef ALU_PADDSB_EN
            OP_PADDSB: aluout_d = lane_sum;
`endif
            OP_LLB:  aluout_d = {s1_a_q[WIDTH-1:8], s1_b_q[7:0]};
            OP_LHB:  aluout_d = {s1_b_q[7:0], s1_a_q[WIDTH-9:0]};
            default: err_d    = 1'b1;
        endcase
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        if (s1_adv) s1_valid_d = 1'b0;
        if (accept) s1_valid_d = 1'b1;

        out_valid_d = out_valid_q;
        if (retire) out_valid_d = 1'b0;
        if (s1_adv) out_valid_d = 1'b1;

        // Flags only move when a flag-setting result actually leaves S2.
        flags_d = flags_q;
        if (retire && fupd_q) begin
            flags_d[FLAG_Z] = (aluout_q == '0);
            flags_d[FLAG_V] = err_q;
            flags_d[FLAG_N] = aluout_q[WIDTH-1];
        end
    end

    // ---- input -> S1 boundary: operand capture ----
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_op_q <= aluop;
            s1_a_q  <= aluin1;
            s1_b_q  <= aluin2;
        end
    end

    // ---- S2 boundary: result register and retired flags ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            aluout_q    <= '0;
            err_q       <= 1'b0;
            fupd_q      <= 1'b0;
            flags_q     <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            flags_q     <= flags_d;
            if (s1_adv) begin
                aluout_q <= aluout_d;
                err_q    <= err_d;
                fupd_q   <= fupd_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign aluout    = aluout_q;
    assign err       = err_q;
    assign flags     = flags_q;

endmodule
